// File: rtl/cipher_out_serializer.sv
// Output stage for the AES encrypt path: a block FIFO feeding a byte serializer with valid/ready on both sides.
// Define CIPHER_MATCH_EN to add per-byte comparison of each emitted block against expected_text.
module cipher_out_serializer #(
    parameter int BLOCK_W   = 128,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BLOCK_W-1:0]           cipher_text,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_byte,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         busy
`ifdef CIPHER_MATCH_EN
    ,
    input  logic [BLOCK_W-1:0]           expected_text,
    output logic [BLOCK_W/8-1:0]         match_flags,
    output logic                         match_valid
`endif
);

    localparam int NBYTES = BLOCK_W / 8;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BLOCK_W-1:0]   shift_q, shift_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [BLOCK_W-1:0]   mem_q [DEPTH];
    logic [BLOCK_W-1:0]   mem_d [DEPTH];

    logic                 wr_en;
    logic                 pop;
    logic                 last_byte;
    logic                 fifo_nonempty;
    logic [IDX_W-1:0]     byte_sel;

    assign in_ready      = (count_q < CNT_W'(DEPTH));
    assign wr_en         = in_valid && in_ready;
    assign fifo_nonempty = (count_q != '0);
    assign last_byte     = (idx_q == IDX_W'(NBYTES - 1));

    assign out_valid  = (state_q == SEND);
    assign out_last   = out_valid && last_byte;
    assign byte_sel   = (LSB_FIRST != 0) ? idx_q : (IDX_W'(NBYTES - 1) - idx_q);
    assign out_byte   = out_valid ? shift_q[{byte_sel, 3'b000} +: 8] : 8'h00;
    assign fifo_count = count_q;
    assign busy       = out_valid || fifo_nonempty;

    // A finishing byte pops the next queued block in the same edge so blocks stream without a bubble.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (!last_byte) begin
                        idx_d = idx_q + 1'b1;
                    end else if (fifo_nonempty) begin
                        pop   = 1'b1;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en) begin
            mem_d[wr_ptr_q] = cipher_text;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef CIPHER_MATCH_EN
    logic [NBYTES-1:0] match_flags_q, match_flags_d;
    logic              match_valid_q, match_valid_d;

    // Flags are indexed by byte position in the block, independent of emission order.
    always_comb begin
        match_flags_d = match_flags_q;
        match_valid_d = 1'b0;
        if (out_valid && out_ready && last_byte) begin
            match_valid_d = 1'b1;
            for (int i = 0; i < NBYTES; i++) begin
                match_flags_d[i] = (shift_q[8*i +: 8] == expected_text[8*i +: 8]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_flags_q <= '0;
            match_valid_q <= 1'b0;
        end else begin
            match_flags_q <= match_flags_d;
            match_valid_q <= match_valid_d;
        end
    end

    assign match_flags = match_flags_q;
    assign match_valid = match_valid_q;
`endif

endmodule

// File: tb/tb_cipher_out_serializer.sv
// Testbench for cipher_out_serializer: one LSB-first and one MSB-first instance share stimulus and are checked
// against a byte-queue reference model; match outputs are checked when CIPHER_MATCH_EN is defined.
module tb_cipher_out_serializer;

    localparam int BLOCK_W = 128;
    localparam int DEPTH   = 4;
    localparam int NBYTES  = BLOCK_W / 8;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [BLOCK_W-1:0] cipher_text = '0;
    logic [BLOCK_W-1:0] exp_text = '0;

    logic               in_ready, out_valid, out_last, busy;
    logic [7:0]         out_byte;
    logic [CNT_W-1:0]   fifo_count;
    logic               in_ready_m, out_valid_m, out_last_m, busy_m;
    logic [7:0]         out_byte_m;
    logic [CNT_W-1:0]   fifo_count_m;
`ifdef CIPHER_MATCH_EN
    logic [NBYTES-1:0]  match_flags, match_flags_m;
    logic               match_valid, match_valid_m;
`endif

    always #5 clk = ~clk;

    cipher_out_serializer #(.BLOCK_W(BLOCK_W), .DEPTH(DEPTH), .LSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .cipher_text(cipher_text),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
        .fifo_count(fifo_count), .busy(busy)
`ifdef CIPHER_MATCH_EN
        , .expected_text(exp_text), .match_flags(match_flags), .match_valid(match_valid)
`endif
    );

    cipher_out_serializer #(.BLOCK_W(BLOCK_W), .DEPTH(DEPTH), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m), .cipher_text(cipher_text),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_byte(out_byte_m), .out_last(out_last_m),
        .fifo_count(fifo_count_m), .busy(busy_m)
`ifdef CIPHER_MATCH_EN
        , .expected_text(exp_text), .match_flags(match_flags_m), .match_valid(match_valid_m)
`endif
    );

    int           checks = 0;
    int           errors = 0;
    logic [8:0]   q_l[$];
    logic [8:0]   q_m[$];
    logic         in_acc = 1'b0;
    int           bytes_acc = 0;
    logic         prev_stall = 1'b0;
    logic [8:0]   prev_out = '0;
`ifdef CIPHER_MATCH_EN
    logic [BLOCK_W-1:0] blk_q[$];
    logic               match_due = 1'b0;
    logic [NBYTES-1:0]  match_exp = '0;
`endif

    task automatic check(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BLOCK_W-1:0] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: each accepted block becomes NBYTES {last, byte} entries per byte order.
    function automatic void push_block(input logic [BLOCK_W-1:0] b);
        for (int i = 0; i < NBYTES; i++) begin
            q_l.push_back({(i == NBYTES - 1), b[8*i +: 8]});
            q_m.push_back({(i == NBYTES - 1), b[8*(NBYTES-1-i) +: 8]});
        end
`ifdef CIPHER_MATCH_EN
        blk_q.push_back(b);
`endif
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_byte"}, out_byte, 8'h00);
        check({tag, "_out_last"}, out_last, 1'b0);
        check({tag, "_fifo_count"}, fifo_count, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_out_valid_msb"}, out_valid_m, 1'b0);
`ifdef CIPHER_MATCH_EN
        check({tag, "_match_flags"}, match_flags, '0);
        check({tag, "_match_valid"}, match_valid, 1'b0);
`endif
    endtask

    // One clock cycle: sample handshakes at the falling edge, update the model, return 1 time unit after the rising edge.
    task automatic step();
        logic [8:0] e;
        @(negedge clk);
        in_acc = in_valid && in_ready;
        check("fifo_count_le_depth", (fifo_count <= CNT_W'(DEPTH)), 1'b1);
        if (prev_stall) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_byte", {out_last, out_byte}, prev_out);
        end
`ifdef CIPHER_MATCH_EN
        check("match_valid", match_valid, match_due);
        check("match_valid_msb", match_valid_m, match_due);
        if (match_due) begin
            check("match_flags", match_flags, match_exp);
            check("match_flags_msb", match_flags_m, match_exp);
        end
        match_due = 1'b0;
`endif
        if (out_valid && out_ready) begin
            check("stream_nonempty", (q_l.size() != 0), 1'b1);
            if (q_l.size() != 0) begin
                e = q_l.pop_front();
                check("byte_lsb", {out_last, out_byte}, e);
                bytes_acc++;
`ifdef CIPHER_MATCH_EN
                if (e[8] && blk_q.size() != 0) begin
                    logic [BLOCK_W-1:0] b;
                    b = blk_q.pop_front();
                    for (int i = 0; i < NBYTES; i++) begin
                        match_exp[i] = (b[8*i +: 8] == exp_text[8*i +: 8]);
                    end
                    match_due = 1'b1;
                end
`endif
            end
        end
        if (out_valid_m && out_ready) begin
            check("stream_nonempty_msb", (q_m.size() != 0), 1'b1);
            if (q_m.size() != 0) begin
                e = q_m.pop_front();
                check("byte_msb", {out_last_m, out_byte_m}, e);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_last, out_byte};
        if (in_acc) push_block(cipher_text);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound, input bit rand_ready, input string tag);
        int n;
        n = 0;
        while ((q_l.size() != 0 || q_m.size() != 0) && n < bound) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        check(tag, q_l.size() + q_m.size(), 0);
    endtask

    initial begin
        logic [BLOCK_W-1:0] blks [6];
        int k;
        int n;

        // Reset state
        #12;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single known block, both byte orders, with latency and match check
        cipher_text = 128'h3925841d02dc09fbdc118597196a0b32;
        exp_text    = 128'h3925841d02dc09fbdc118597196a0b32 ^ (128'hff << 24);
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        step();
        check("t1_accept", in_acc, 1'b1);
        in_valid = 1'b0;
        check("t1_valid_edge1", out_valid, 1'b0);
        check("t1_count_edge1", fifo_count, 1);
        check("t1_busy_edge1", busy, 1'b1);
        step();
        check("t1_valid_edge2", out_valid, 1'b1);
        check("t1_first_lsb", out_byte, 8'h32);
        check("t1_first_msb", out_byte_m, 8'h39);
        check("t1_first_last", out_last, 1'b0);
        check("t1_count_edge2", fifo_count, 0);
        drain(40, 1'b0, "t1_drain");
`ifdef CIPHER_MATCH_EN
        check("t1_match_pulse", match_valid, 1'b1);
        check("t1_match_flags", match_flags, 16'hfff7);
`endif
        step();
        step();
        check("t1_idle_valid", out_valid, 1'b0);
        check("t1_idle_busy", busy, 1'b0);
        exp_text = '0;

        // Back-pressure until full, then release with no gaps between blocks
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) blks[i] = rand_block();
        k = 0;
        n = 0;
        while (k < 5 && n < 50) begin
            in_valid    = 1'b1;
            cipher_text = blks[k];
            step();
            if (in_acc) k++;
            n++;
        end
        check("full_accepted", k, 5);
        cipher_text = blks[5];
        repeat (3) begin
            step();
            check("full_hold", in_acc, 1'b0);
        end
        check("full_in_ready", in_ready, 1'b0);
        check("full_count", fifo_count, 4);
        check("full_busy", busy, 1'b1);
        out_ready = 1'b1;
        n = 0;
        k = 0;
        while (q_l.size() != 0 && n < 200) begin
            check("full_no_gap", out_valid, 1'b1);
            step();
            if (in_acc) begin
                k++;
                in_valid = 1'b0;
            end
            n++;
        end
        check("full_sixth_taken", k, 1);
        check("full_drain", q_l.size() + q_m.size(), 0);

        // Random traffic on both sides
        k = 0;
        n = 0;
        cipher_text = rand_block();
        while (k < 20 && n < 3000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
            if (in_acc) begin
                k++;
                cipher_text = rand_block();
            end
        end
        in_valid = 1'b0;
        check("rand_written", k, 20);
        drain(2000, 1'b1, "rand_drain");

        // Asynchronous reset in the middle of a block with two more queued
        out_ready = 1'b0;
        k = 0;
        n = 0;
        cipher_text = rand_block();
        while (k < 3 && n < 50) begin
            in_valid = 1'b1;
            step();
            if (in_acc) begin
                k++;
                cipher_text = rand_block();
            end
            n++;
        end
        in_valid = 1'b0;
        step();
        step();
        check("rst_queued", fifo_count, 2);
        out_ready = 1'b1;
        bytes_acc = 0;
        n = 0;
        while (bytes_acc < 7 && n < 50) begin
            step();
            n++;
        end
        check("rst_bytes_before", bytes_acc, 7);
        check("rst_mid_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        q_l.delete();
        q_m.delete();
        prev_stall = 1'b0;
`ifdef CIPHER_MATCH_EN
        blk_q.delete();
        match_due = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            step();
            check("post_reset_idle", out_valid, 1'b0);
        end
        check("post_reset_count", fifo_count, 0);
        cipher_text = rand_block();
        in_valid    = 1'b1;
        step();
        check("post_reset_accept", in_acc, 1'b1);
        in_valid = 1'b0;
        drain(60, 1'b0, "post_reset_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
